epmp_mem_resp: RTL and testbench
================================

EPMP_MEM_RESP -- requirements
Module: epmp_mem_resp

Interface
REQ-001 SHALL provide parameter WAIT_CYCLES, default 2, meaning the number of wait cycles inserted before Ready (legal range 0..15).
REQ-002 SHALL provide parameter WP_LIMIT, default 8'h0F, meaning the highest write-protected address (used only with EPMP_MEM_WP_EN).
REQ-003 SHALL have port clk  input  1  system clock, rising edge.
REQ-004 SHALL have port Reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port Addr  input  8  address from the initiator's MAR.
REQ-006 SHALL have port Data_In  input  8  write data from the initiator's MDR external side.
REQ-007 SHALL have port Read  input  1  read strobe, level, held until Ready is seen.
REQ-008 SHALL have port Write  input  1  write strobe, level, held until Ready is seen.
REQ-009 SHALL have port Data_Out  output  8  read data, valid while Ready=1 on a read.
REQ-010 SHALL have port Data_Out_En  output  1  bus-drive enable, equal to Ready AND read access.
REQ-011 SHALL have port Ready  output  1  one-cycle completion pulse.
REQ-012 SHALL have port Busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port Err  output  1  protocol/protection error, pulses together with Ready.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, ACK and HOLD.
REQ-015 In IDLE, Read XOR Write or Read AND Write sampled high SHALL capture Addr, Data_In and the op into registers, load the wait counter with WAIT_CYCLES, and go to WAIT (or to ACK if WAIT_CYCLES=0).
REQ-016 WAIT SHALL decrement the counter each cycle and go to ACK on the cycle the counter reaches 0.
REQ-017 Ready SHALL be high exactly WAIT_CYCLES+1 cycles after the edge that sampled the strobe, for exactly one cycle (state ACK).
REQ-018 A write SHALL update the array on the edge leaving ACK, using the captured address and data; later changes to Addr or Data_In SHALL NOT affect the access.
REQ-019 A read SHALL present mem[captured Addr] on Data_Out during ACK; Data_Out SHALL be 8'h00 in all other states.
REQ-020 Read AND Write both high at capture SHALL perform no array access and SHALL pulse Err and Ready together in ACK.
REQ-021 ACK SHALL go to HOLD; HOLD SHALL stay until Read=0 and Write=0 are sampled, then go to IDLE, so that a held strobe never starts a second access.
REQ-022 Strobes deasserted early, during WAIT, SHALL NOT abort the access; the access completes normally.

Reset
REQ-023 Reset SHALL force IDLE, counter 0, Ready=0, Err=0, Busy=0, Data_Out=8'h00, Data_Out_En=0, including mid-access; a pending write SHALL be dropped.
REQ-024 Array contents SHALL NOT be cleared by Reset.

Configuration
REQ-025 Macro EPMP_MEM_WP_EN defined: a write with captured Addr<=WP_LIMIT SHALL leave the array unchanged and pulse Err with Ready.
REQ-026 Without EPMP_MEM_WP_EN, all addresses SHALL be writable and Err SHALL assert only per REQ-020.

Structure
REQ-027 State encodings (IDLE=2'd0, WAIT=2'd1, ACK=2'd2, HOLD=2'd3) and the counter width constant SHALL live in shared package epmp_mem_pkg.
REQ-028 Storage SHALL be sub-module epmp_mem_array: 256x8, write port and combinational read, no reset.

Verification
REQ-029 WAIT_CYCLES=2, Write=1, Addr=8'h40, Data_In=8'hA5 held -> Ready high exactly 3 cycles after the sample; Err=0; FSM stays in HOLD until Write=0.
REQ-030 Read=1, Addr=8'h40 after REQ-029 -> Data_Out=8'hA5 and Data_Out_En=1 only in the Ready cycle; Data_Out=8'h00 otherwise.
REQ-031 Read=1 and Write=1 simultaneously, Addr=8'h41 -> Ready and Err pulse together; mem[8'h41] unchanged.
REQ-032 Reset asserted in WAIT during a write to 8'h50 -> next cycle IDLE, Busy=0, no Ready; mem[8'h50] keeps its prior value.
REQ-033 EPMP_MEM_WP_EN defined, write 8'hFF to 8'h05 -> Err and Ready pulse, mem[8'h05] unchanged; write to 8'h10 succeeds with Err=0.
REQ-034 WAIT_CYCLES=0, Read held 5 cycles -> exactly one Ready pulse, 1 cycle after the sample.

Source files
------------

// File: rtl/epmp_mem_pkg.sv
// epmp_mem_pkg -- shared definitions for the epmp_mem_resp memory responder.
//   state_t : responder FSM encoding (IDLE/WAIT/ACK/HOLD)
//   op_t    : access kind captured from the Read/Write strobes
//   CNT_W   : width of the wait-cycle counter (WAIT_CYCLES range 0..15)
package epmp_mem_pkg;

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OP_READ  = 2'd0,
      OP_WRITE = 2'd1,
      OP_BOTH  = 2'd2
   } op_t;

endpackage

// File: rtl/epmp_mem_resp_if.sv
// epmp_mem_resp_if -- initiator <-> memory responder bus.
//   master : drives Addr, Data_In, Read, Write; receives Data_Out,
//            Data_Out_En, Ready, Busy, Err
//   slave  : the responder side (mirror of master)
interface epmp_mem_resp_if;

   logic [7:0] Addr;
   logic [7:0] Data_In;
   logic       Read;
   logic       Write;
   logic [7:0] Data_Out;
   logic       Data_Out_En;
   logic       Ready;
   logic       Busy;
   logic       Err;

   modport master (
      output Addr, Data_In, Read, Write,
      input  Data_Out, Data_Out_En, Ready, Busy, Err
   );

   modport slave (
      input  Addr, Data_In, Read, Write,
      output Data_Out, Data_Out_En, Ready, Busy, Err
   );

endinterface

// File: rtl/epmp_mem_array.sv
// epmp_mem_array -- 256x8 storage, no reset.
//   clk     : write clock (rising edge)
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address (combinational read)
//   rdata_o : read data
module epmp_mem_array (
   input  logic       clk,
   input  logic       we_i,
   input  logic [7:0] waddr_i,
   input  logic [7:0] wdata_i,
   input  logic [7:0] raddr_i,
   output logic [7:0] rdata_o
);

   logic [7:0] mem_q [256];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/epmp_mem_resp.sv
// epmp_mem_resp -- wait-state memory responder in front of a 256x8 array.
//   clk   : system clock, rising edge
//   Reset : synchronous, active-high; array contents are kept
//   bus   : epmp_mem_resp_if.slave (Addr, Data_In, Read, Write in;
//           Data_Out, Data_Out_En, Ready, Busy, Err out)
// Parameters: WAIT_CYCLES (0..15) wait cycles before Ready;
//             WP_LIMIT highest write-protected address.
// Build option: define EPMP_MEM_WP_EN to make writes to Addr<=WP_LIMIT
// fail with Err instead of updating the array.
module epmp_mem_resp
   import epmp_mem_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [7:0]  WP_LIMIT    = 8'h0F
) (
   input  logic              clk,
   input  logic              Reset,
   epmp_mem_resp_if.slave    bus
);

`ifdef EPMP_MEM_WP_EN
   localparam bit WP_EN = 1'b1;
`else
   localparam bit WP_EN = 1'b0;
`endif

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   op_t                op_q;
   logic               fault_q;
   logic [7:0]         addr_q;
   logic [7:0]         wdata_q;
   logic               ready_q;
   logic               err_q;
   logic               busy_q;
   logic               doe_q;
   logic [7:0]         dout_q;

   op_t                cap_op;
   logic               cap_fault;
   op_t                acc_op;
   logic               acc_fault;
   logic [7:0]         rd_addr;
   logic [7:0]         rd_data;
   logic               we;

   // ACK can be entered straight from IDLE (WAIT_CYCLES=0), so the access
   // attributes and read address come from the live bus in IDLE and from
   // the captured registers otherwise.
   always_comb begin
      cap_op = OP_READ;
      if (bus.Read && bus.Write) cap_op = OP_BOTH;
      else if (bus.Write)        cap_op = OP_WRITE;
      cap_fault = (cap_op == OP_BOTH) ||
                  ((cap_op == OP_WRITE) && WP_EN && (bus.Addr <= WP_LIMIT));
      if (state_q == ST_IDLE) begin
         acc_op    = cap_op;
         acc_fault = cap_fault;
         rd_addr   = bus.Addr;
      end else begin
         acc_op    = op_q;
         acc_fault = fault_q;
         rd_addr   = addr_q;
      end
      // Write lands on the edge leaving ACK; a reset on that edge drops it.
      we = (state_q == ST_ACK) && (op_q == OP_WRITE) && !fault_q && !Reset;
   end

   epmp_mem_array u_array (
      .clk     (clk),
      .we_i    (we),
      .waddr_i (addr_q),
      .wdata_i (wdata_q),
      .raddr_i (rd_addr),
      .rdata_o (rd_data)
   );

   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= OP_READ;
         fault_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         doe_q   <= 1'b0;
         dout_q  <= '0;
      end else begin
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         doe_q   <= 1'b0;
         dout_q  <= '0;
         case (state_q)
            ST_IDLE: begin
               busy_q <= 1'b0;
               if (bus.Read || bus.Write) begin
                  op_q    <= cap_op;
                  fault_q <= cap_fault;
                  addr_q  <= bus.Addr;
                  wdata_q <= bus.Data_In;
                  busy_q  <= 1'b1;
                  if (WAIT_CYCLES == 0) begin
                     state_q <= ST_ACK;
                     cnt_q   <= '0;
                     ready_q <= 1'b1;
                     err_q   <= acc_fault;
                     doe_q   <= (acc_op == OP_READ);
                     dout_q  <= (acc_op == OP_READ) ? rd_data : '0;
                  end else begin
                     state_q <= ST_WAIT;
                     cnt_q   <= CNT_W'(WAIT_CYCLES);
                  end
               end
            end
            ST_WAIT: begin
               busy_q <= 1'b1;
               cnt_q  <= cnt_q - 1'b1;
               // Counter hits zero on this edge: enter ACK now.
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= ST_ACK;
                  ready_q <= 1'b1;
                  err_q   <= acc_fault;
                  doe_q   <= (acc_op == OP_READ);
                  dout_q  <= (acc_op == OP_READ) ? rd_data : '0;
               end
            end
            ST_ACK: begin
               busy_q  <= 1'b1;
               state_q <= ST_HOLD;
            end
            ST_HOLD: begin
               if (!bus.Read && !bus.Write) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  busy_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.Ready       = ready_q;
   assign bus.Err         = err_q;
   assign bus.Busy        = busy_q;
   assign bus.Data_Out    = dout_q;
   assign bus.Data_Out_En = doe_q;

endmodule

// File: tb/tb_epmp_mem_resp.sv
// tb_epmp_mem_resp -- self-checking bench for epmp_mem_resp.
// dut0 uses WAIT_CYCLES=2, dut1 uses WAIT_CYCLES=0. Expected responses are
// queued when an access is launched and popped once the access completes.
module tb_epmp_mem_resp;

   logic clk = 1'b0;
   logic Reset = 1'b1;
   always #5 clk = ~clk;

   epmp_mem_resp_if b0 ();
   epmp_mem_resp_if b1 ();

   epmp_mem_resp #(.WAIT_CYCLES(2), .WP_LIMIT(8'h0F)) dut0 (
      .clk(clk), .Reset(Reset), .bus(b0));
   epmp_mem_resp #(.WAIT_CYCLES(0), .WP_LIMIT(8'h0F)) dut1 (
      .clk(clk), .Reset(Reset), .bus(b1));

   typedef struct packed {
      logic [7:0] lat;     // negedges after the sampling edge until Ready
      logic [7:0] nready;  // Ready pulses seen during the access
      logic [7:0] data;
      logic       doe;
      logic       err;
   } res_t;

   res_t       exp_q[$];
   logic [7:0] model [256];
   int         asserts = 0;
   int         fails   = 0;

   function automatic string fmt(input res_t r);
      return $sformatf("lat=%0d n=%0d data=%h doe=%b err=%b",
                       r.lat, r.nready, r.data, r.doe, r.err);
   endfunction

   function automatic res_t mk(input int lat, input int n, input logic [7:0] d,
                               input logic doe, input logic err);
      res_t r;
      r.lat = 8'(lat); r.nready = 8'(n); r.data = d; r.doe = doe; r.err = err;
      return r;
   endfunction

   task automatic set_in(input int d, input logic rd, input logic wr,
                         input logic [7:0] a, input logic [7:0] dn);
      if (d == 0) begin
         b0.Read = rd; b0.Write = wr; b0.Addr = a; b0.Data_In = dn;
      end else begin
         b1.Read = rd; b1.Write = wr; b1.Addr = a; b1.Data_In = dn;
      end
   endtask

   task automatic get_out(input int d, output logic rdy, output logic er,
                          output logic bsy, output logic de, output logic [7:0] dq);
      if (d == 0) begin
         rdy = b0.Ready; er = b0.Err; bsy = b0.Busy; de = b0.Data_Out_En; dq = b0.Data_Out;
      end else begin
         rdy = b1.Ready; er = b1.Err; bsy = b1.Busy; de = b1.Data_Out_En; dq = b1.Data_Out;
      end
   endtask

   // Runs one access. Addr/Data_In are scrambled after the sampling edge.
   // early>0: strobes dropped at that negedge; else held until extra cycles
   // after Ready. Bounded to 40 cycles; a missing Ready leaves lat=8'hFF.
   task automatic drive(input int d, input logic rd, input logic wr,
                        input logic [7:0] a, input logic [7:0] dn,
                        input int early, input int extra,
                        output res_t o, output int bad_idle, output int busy_drop);
      logic rdy, er, bsy, de;
      logic [7:0] dq;
      bit held;
      int lat;
      lat = -1;
      o = mk(-1, 0, 8'h00, 1'b0, 1'b0);
      bad_idle = 0; busy_drop = 0;
      set_in(d, rd, wr, a, dn);
      held = 1'b1;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         get_out(d, rdy, er, bsy, de, dq);
         if (rdy) begin
            o.nready = o.nready + 8'd1;
            if (lat < 0) begin
               lat = cyc; o.lat = 8'(cyc); o.data = dq; o.doe = de; o.err = er;
            end
         end else if (dq !== 8'h00 || de !== 1'b0 || er !== 1'b0) begin
            bad_idle++;
         end
         if (held && lat >= 0 && !rdy && !bsy) busy_drop++;
         if (!held && o.nready != 0 && !bsy) break;
         if (cyc == 1) set_in(d, rd, wr, ~a, ~dn);
         if (held && ((early > 0 && cyc >= early) ||
                      (early == 0 && lat >= 0 && cyc >= lat + extra))) begin
            set_in(d, 1'b0, 1'b0, ~a, ~dn);
            held = 1'b0;
         end
      end
      set_in(d, 1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   task automatic test_reset();
      logic rdy, er, bsy, de;
      logic [7:0] dq;
      set_in(0, 1'b0, 1'b0, 8'h00, 8'h00);
      set_in(1, 1'b0, 1'b0, 8'h00, 8'h00);
      Reset = 1'b1;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         get_out(d, rdy, er, bsy, de, dq);
         asserts++;
         if ({rdy, er, bsy, de, dq} !== 12'h000) begin
            fails++;
            $display("FAIL reset_state dut%0d got rdy=%b err=%b busy=%b doe=%b dout=%h want all zero",
                     d, rdy, er, bsy, de, dq);
         end
      end
      Reset = 1'b0;
   endtask

   // One access with its scoreboard entry; also checks idle-cycle outputs
   // and that Busy stays high while a strobe is held after Ready.
   task automatic test_access(input string name, input int d, input logic rd,
                              input logic wr, input logic [7:0] a,
                              input logic [7:0] dn, input int early,
                              input int extra, input res_t e);
      res_t o, x;
      int bi, bd;
      exp_q.push_back(e);
      drive(d, rd, wr, a, dn, early, extra, o, bi, bd);
      x = exp_q.pop_front();
      asserts++;
      if (o !== x) begin
         fails++;
         $display("FAIL %s got %s want %s", name, fmt(o), fmt(x));
      end
      asserts++;
      if (bi != 0 || bd != 0) begin
         fails++;
         $display("FAIL %s_idle got bad_idle=%0d busy_drop=%0d want 0 0", name, bi, bd);
      end
   endtask

   task automatic test_write_read();
      test_access("write40", 0, 1'b0, 1'b1, 8'h40, 8'hA5, 0, 3, mk(3, 1, 8'h00, 1'b0, 1'b0));
      model[8'h40] = 8'hA5;
      test_access("read40", 0, 1'b1, 1'b0, 8'h40, 8'h00, 0, 2, mk(3, 1, model[8'h40], 1'b1, 1'b0));
   endtask

   task automatic test_both_strobes();
      test_access("write41", 0, 1'b0, 1'b1, 8'h41, 8'h5A, 0, 0, mk(3, 1, 8'h00, 1'b0, 1'b0));
      model[8'h41] = 8'h5A;
      test_access("both41", 0, 1'b1, 1'b1, 8'h41, 8'hEE, 0, 1, mk(3, 1, 8'h00, 1'b0, 1'b1));
      test_access("read41", 0, 1'b1, 1'b0, 8'h41, 8'h00, 0, 0, mk(3, 1, model[8'h41], 1'b1, 1'b0));
   endtask

   task automatic test_early_drop();
      test_access("early_wr60", 0, 1'b0, 1'b1, 8'h60, 8'h77, 1, 0, mk(3, 1, 8'h00, 1'b0, 1'b0));
      model[8'h60] = 8'h77;
      test_access("early_rd60", 0, 1'b1, 1'b0, 8'h60, 8'h00, 2, 0, mk(3, 1, model[8'h60], 1'b1, 1'b0));
   endtask

   task automatic test_reset_mid();
      logic rdy, er, bsy, de;
      logic [7:0] dq;
      test_access("pre_wr50", 0, 1'b0, 1'b1, 8'h50, 8'h3C, 0, 0, mk(3, 1, 8'h00, 1'b0, 1'b0));
      model[8'h50] = 8'h3C;
      set_in(0, 1'b0, 1'b1, 8'h50, 8'h99);
      @(negedge clk);                 // sampled: now in WAIT
      get_out(0, rdy, er, bsy, de, dq);
      asserts++;
      if (rdy !== 1'b0 || bsy !== 1'b1) begin
         fails++;
         $display("FAIL reset_mid_wait got rdy=%b busy=%b want 0 1", rdy, bsy);
      end
      Reset = 1'b1;
      @(negedge clk);
      get_out(0, rdy, er, bsy, de, dq);
      asserts++;
      if ({rdy, er, bsy, de, dq} !== 12'h000) begin
         fails++;
         $display("FAIL reset_mid got rdy=%b err=%b busy=%b doe=%b dout=%h want all zero",
                  rdy, er, bsy, de, dq);
      end
      set_in(0, 1'b0, 1'b0, 8'h00, 8'h00);
      Reset = 1'b0;
      @(negedge clk);
      test_access("post_rd50", 0, 1'b1, 1'b0, 8'h50, 8'h00, 0, 0, mk(3, 1, model[8'h50], 1'b1, 1'b0));
   endtask

   task automatic test_write_protect();
      res_t o, x;
      int bi, bd;
`ifdef EPMP_MEM_WP_EN
      test_access("wp_wr05", 0, 1'b0, 1'b1, 8'h05, 8'hFF, 0, 0, mk(3, 1, 8'h00, 1'b0, 1'b1));
      drive(0, 1'b1, 1'b0, 8'h05, 8'h00, 0, 0, o, bi, bd);
      asserts++;
      if (o.lat !== 8'd3 || o.err !== 1'b0 || o.doe !== 1'b1 || o.data === 8'hFF) begin
         fails++;
         $display("FAIL wp_rd05 got %s want lat=3 err=0 doe=1 data!=ff", fmt(o));
      end
`else
      test_access("nowp_wr05", 0, 1'b0, 1'b1, 8'h05, 8'hFF, 0, 0, mk(3, 1, 8'h00, 1'b0, 1'b0));
      model[8'h05] = 8'hFF;
      test_access("nowp_rd05", 0, 1'b1, 1'b0, 8'h05, 8'h00, 0, 0, mk(3, 1, model[8'h05], 1'b1, 1'b0));
`endif
      test_access("wr10", 0, 1'b0, 1'b1, 8'h10, 8'hC3, 0, 0, mk(3, 1, 8'h00, 1'b0, 1'b0));
      model[8'h10] = 8'hC3;
      exp_q.push_back(mk(3, 1, model[8'h10], 1'b1, 1'b0));
      drive(0, 1'b1, 1'b0, 8'h10, 8'h00, 0, 0, o, bi, bd);
      x = exp_q.pop_front();
      asserts++;
      if (o !== x) begin
         fails++;
         $display("FAIL rd10 got %s want %s", fmt(o), fmt(x));
      end
   endtask

   task automatic test_wait0();
      test_access("w0_wr22", 1, 1'b0, 1'b1, 8'h22, 8'h6B, 0, 0, mk(1, 1, 8'h00, 1'b0, 1'b0));
      test_access("w0_rd22_held", 1, 1'b1, 1'b0, 8'h22, 8'h00, 0, 4, mk(1, 1, 8'h6B, 1'b1, 1'b0));
   endtask

   task automatic test_back_to_back();
      logic [7:0] a, dv;
      for (int i = 0; i < 6; i++) begin
         a  = 8'h80 + 8'(i * 5);
         dv = 8'($urandom_range(0, 255));
         model[a] = dv;
         test_access($sformatf("b2b_wr%0d", i), 0, 1'b0, 1'b1, a, dv, 0, 0,
                     mk(3, 1, 8'h00, 1'b0, 1'b0));
      end
      for (int i = 5; i >= 0; i--) begin
         a = 8'h80 + 8'(i * 5);
         test_access($sformatf("b2b_rd%0d", i), 0, 1'b1, 1'b0, a, 8'h00, 0, 0,
                     mk(3, 1, model[a], 1'b1, 1'b0));
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_both_strobes();
      test_early_drop();
      test_reset_mid();
      test_write_protect();
      test_wait0();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish within 200000 time units");
      $fatal(1);
   end

endmodule
